// File: rtl/slide_pot_sequencer.sv
// Round-robin sequencer for the six slide pots on the shared ADC128S SPI link.
// Each channel is converted with two SPI transactions; only the second returns valid data.
module slide_pot_sequencer #(
    parameter int unsigned SWEEP_GAP = 1024,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pause,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic [11:0] LP_gain,
    output logic [11:0] B1_gain,
    output logic [11:0] B2_gain,
    output logic [11:0] B3_gain,
    output logic [11:0] HP_gain,
    output logic [11:0] VOL,
    output logic        pots_valid,
    output logic        sweep_done,
    output logic        timeout_err
);

    localparam logic [3:0] GAP      = 4'd0;
    localparam logic [3:0] CMD      = 4'd1;
    localparam logic [3:0] WAIT_CMD = 4'd2;
    localparam logic [3:0] DLY      = 4'd3;
    localparam logic [3:0] RD       = 4'd4;
    localparam logic [3:0] WAIT_RD  = 4'd5;
    localparam logic [3:0] STORE    = 4'd6;
    localparam logic [3:0] NEXT     = 4'd7;
    localparam logic [3:0] HOLD     = 4'd8;

    localparam int unsigned GAP_W = $clog2(SWEEP_GAP + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SWEEP_GAP - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    logic [3:0]       state;
    logic [GAP_W-1:0] gap_cnt;
    logic [TO_W-1:0]  wd_cnt;
    logic [2:0]       idx;
    logic [2:0]       chnl;
    logic [11:0]      rd_data;
    logic [11:0]      gain [6];
    logic [5:0]       valid;
    logic             unused_rd_hi;

    assign unused_rd_hi = ^spi_rd[15:12];

    always_comb begin
        case (idx)
            3'd0:    chnl = 3'd1;
            3'd1:    chnl = 3'd0;
            3'd2:    chnl = 3'd4;
            3'd3:    chnl = 3'd2;
            3'd4:    chnl = 3'd3;
            default: chnl = 3'd7;
        endcase
    end

    assign spi_wrt    = (state == CMD) || (state == RD);
    assign spi_cmd    = spi_wrt ? {2'b00, chnl, 11'h000} : '0;
    assign sweep_done = (state == NEXT) && (idx == 3'd5);
    assign pots_valid = &valid;

    assign LP_gain = gain[0];
    assign B1_gain = gain[1];
    assign B2_gain = gain[2];
    assign B3_gain = gain[3];
    assign HP_gain = gain[4];
    assign VOL     = gain[5];

    // Watchdog restarts on every state entry; spi_done wins over a coinciding expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= GAP;
            gap_cnt     <= '0;
            wd_cnt      <= '0;
            idx         <= '0;
            rd_data     <= '0;
            valid       <= '0;
            timeout_err <= 1'b0;
            for (int unsigned i = 0; i < 6; i++) gain[i] <= '0;
        end else begin
            wd_cnt <= '0;
            case (state)
                GAP: begin
                    if (!pause) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= '0;
                            state   <= CMD;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                CMD: state <= WAIT_CMD;
                WAIT_CMD: begin
                    if (spi_done) begin
                        state <= DLY;
                    end else if (wd_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= NEXT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DLY: state <= RD;
                RD:  state <= WAIT_RD;
                WAIT_RD: begin
                    if (spi_done) begin
                        rd_data <= spi_rd[11:0];
                        state   <= STORE;
                    end else if (wd_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= NEXT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                STORE: begin
                    gain[idx]  <= rd_data;
                    valid[idx] <= 1'b1;
                    state      <= NEXT;
                end
                NEXT: begin
                    if (idx == 3'd5) begin
                        idx     <= '0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= pause ? HOLD : CMD;
                    end
                end
                HOLD: if (!pause) state <= CMD;
                default: state <= GAP;
            endcase
        end
    end

endmodule

// File: doc/slide_pot_sequencer.md
Name: slide_pot_sequencer

Overview:
- Owns the shared SPI A2D link to the ADC128S and schedules conversions of the six slide pots: LP, B1, B2, B3, HP, VOL.
- Sweeps the channels round-robin through the existing 16-bit SPI master handshake.
- Holds the last good 12-bit value per pot and feeds them to the Equalizer band gain and volume datapath.
- Sits between the SPI master and the band-scaling logic inside Equalizer.

Parameters:
SWEEP_GAP, 1024, idle cycles between the end of one sweep and the start of the next (must be >=1)
TIMEOUT, 4096, max cycles waiting for spi_done per transaction before abort

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pause  input  1  level; when high, halt after the current channel completes
spi_wrt  output  1  one-cycle pulse that starts an SPI transaction
spi_cmd  output  16  command word, valid while spi_wrt is high
spi_done  input  1  one-cycle pulse from SPI master, transaction complete
spi_rd  input  16  data returned by SPI master, valid in the spi_done cycle
LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOL  output  12 each  last stored pot values
pots_valid  output  1  high once every channel has stored at least one good value
sweep_done  output  1  one-cycle pulse when the last channel (VOL) of a sweep finishes
timeout_err  output  1  sticky; set on any transaction timeout

Behaviour:
- Reset (async, rst_n low):
  - all gains = 12'h000, VOL = 12'h000
  - pots_valid, sweep_done, timeout_err, spi_wrt = 0; spi_cmd = 16'h0000
  - state = GAP, gap counter = 0, channel index = 0
- Channel order (index 0..5 -> ADC channel): LP=1, B1=0, B2=4, B3=2, HP=3, VOL=7.
- Command word: {2'b00, chnl[2:0], 11'h000}.
- States:
  - GAP: count to SWEEP_GAP-1 with pause low -> CMD. Counter holds while pause is high.
  - CMD: spi_wrt=1 for exactly one cycle with channel command -> WAIT_CMD.
  - WAIT_CMD: on spi_done -> DLY. spi_rd is ignored here (it is stale data).
  - DLY: one idle cycle -> RD.
  - RD: spi_wrt=1 for one cycle, same command word -> WAIT_RD.
  - WAIT_RD: on spi_done -> STORE.
  - STORE: the selected gain <= spi_rd[11:0], its valid bit is set, then NEXT.
  - NEXT:
    - index 5: pulse sweep_done, index wraps to 0 -> GAP.
    - else: index+1; -> CMD if pause low, else -> HOLD.
  - HOLD: -> CMD when pause is low.
- Timing: minimum latency from spi_wrt in CMD to gain update is 2 SPI transactions + 4 cycles. The gain register updates on the clk edge ending the STORE cycle.
- Watchdog:
  - A counter runs in WAIT_CMD and WAIT_RD.
  - When it reaches TIMEOUT with no spi_done: set timeout_err, leave that gain unchanged, leave its valid bit unchanged, -> NEXT.
  - The counter clears on every state entry.
- spi_done outside WAIT_CMD/WAIT_RD is ignored.
- spi_done in the same cycle the watchdog expires: treat as success, do not set the error.
- pots_valid = AND of the six per-channel valid bits. It never clears except at reset.
- pause:
  - sampled only in GAP, NEXT and HOLD.
  - asserting it mid-transaction does not abort; the current channel finishes and is stored.
- Reset mid-transaction: immediate return to reset values. The SPI master is reset by the same rst_n. No partial store.
- Only one spi_wrt is ever outstanding. spi_wrt is never asserted in consecutive cycles.

Test Plan:
- Reset release with an SPI master model returning 12'hA00+chnl on every read:
  - after SWEEP_GAP cycles, the first spi_cmd = 16'h0800 (LP, ch1).
  - command order is 0800, 0000, 2000, 1000, 1800, 3800.
  - LP_gain=A01, B1_gain=A00, B2_gain=A04, B3_gain=A02, HP_gain=A03, VOL=A07.
  - sweep_done pulses once; pots_valid rises in the same cycle the VOL gain updates.
- Stale-data check: model returns 16'hFFFF on the first transaction and 12'h800 on the second -> B3_gain = 12'h800, never FFF.
- Timeout: model withholds spi_done for the B2 read -> after TIMEOUT cycles timeout_err=1, B2_gain keeps its prior value, and the next command is 16'h1000 (B3). pots_valid stays 0 if B2 has never succeeded.
- Pause: raise pause during the B1 WAIT_RD -> B1 is stored, no further spi_wrt while paused; drop pause -> the next command is 16'h2000.
- Reset mid-sweep: drop rst_n in WAIT_RD of HP -> all gains 0, pots_valid=0 and timeout_err=0 immediately; after release the sweep restarts at LP.
- Simultaneous events: spi_done coincides with watchdog expiry -> value stored, timeout_err stays 0.
